// File: rtl/spi_pkg.sv
// Shared SPI constants: mode encodings and the slave FSM state type.
package spi_pkg;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Slave transfer state: waiting for select, or inside a select frame
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input with rise/fall detection
// on the last two synchronised samples.
module spi_edge_sync #(
    parameter int unsigned DEPTH   = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;

    // Shift the raw input through the chain and keep one older sample for edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= {DEPTH{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
            prev_q <= sync_q[DEPTH-1];
        end
    end

    assign rise_c = sync_q[DEPTH-1] & ~prev_q;
    assign fall_c = ~sync_q[DEPTH-1] & prev_q;

endmodule

// File: rtl/spi_slave_word.sv
// SPI slave that receives and transmits fixed-width words, oversampling
// sck/csn/mosi with the system clock, with a one-word transmit holding buffer.
module spi_slave_word
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter bit          CPOL        = 1'b1,
    parameter bit          CPHA        = 1'b1,
    parameter bit          LSB_FIRST   = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             csn,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    spi_state_e             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WIDTH-1:0]       rx_shift;
    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-1:0]       hold_data;
    logic [SYNC_STAGES-1:0] mosi_sync_q;

    logic sck_rise_c, sck_fall_c, csn_rise_c, csn_fall_c;
    logic lead_c, trail_c, sample_c, shift_c;
    logic mosi_s_c, in_frame_c, entry_c, load_c, accept_c;
    logic [WIDTH-1:0] rx_next_c, tx_next_c;

    spi_edge_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
        .clk    (clk),
        .rstn   (rstn),
        .d      (sck),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    spi_edge_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .clk    (clk),
        .rstn   (rstn),
        .d      (csn),
        .rise_c (csn_rise_c),
        .fall_c (csn_fall_c)
    );

    // Plain synchroniser for mosi, same depth as sck so data and clock stay aligned
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s_c = mosi_sync_q[SYNC_STAGES-1];

    // Leading edge leaves the idle level; sampling and shifting swap with CPHA
    assign lead_c   = CPOL ? sck_fall_c : sck_rise_c;
    assign trail_c  = CPOL ? sck_rise_c : sck_fall_c;
    assign sample_c = CPHA ? trail_c : lead_c;
    assign shift_c  = CPHA ? lead_c : trail_c;

    // A select release wins over any sck edge seen in the same clk
    assign in_frame_c = (state == ST_ACTIVE) && !csn_rise_c;
    assign entry_c    = (state == ST_IDLE) && csn_fall_c;

    // CPHA=0 must present bit 0 before the first edge, so it also loads on select
    assign load_c   = (!CPHA && entry_c) || (in_frame_c && shift_c && (bit_cnt == '0));
    assign accept_c = tx_valid && tx_ready;

    assign rx_next_c = LSB_FIRST ? {mosi_s_c, rx_shift[WIDTH-1:1]}
                                 : {rx_shift[WIDTH-2:0], mosi_s_c};
    assign tx_next_c = LSB_FIRST ? {1'b0, tx_shift[WIDTH-1:1]}
                                 : {tx_shift[WIDTH-2:0], 1'b0};

    // Frame FSM, bit counter and receive word assembly
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (csn_fall_c) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (csn_rise_c) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                    end else if (sample_c) begin
                        rx_shift <= rx_next_c;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            rx_data  <= rx_next_c;
                            rx_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // Transmit holding buffer and output shift register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_shift    <= '0;
            hold_data   <= '0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load_c) begin
                if (!tx_ready) begin
                    tx_shift <= hold_data;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift    <= '0;
                    tx_underrun <= 1'b1;
                end
            end else if (in_frame_c && shift_c) begin
                tx_shift <= tx_next_c;
            end
            // An accept only happens with the buffer empty, so it never clobbers a load
            if (accept_c) begin
                hold_data <= tx_data;
                tx_ready  <= 1'b0;
            end
        end
    end

    assign miso    = LSB_FIRST ? tx_shift[0] : tx_shift[WIDTH-1];
    assign busy    = (state == ST_ACTIVE);
    assign miso_oe = (state == ST_ACTIVE);

endmodule

// File: doc/spi_slave_word.md
SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 8: bits per SPI word, legal range 4..32.
- CPOL, default 1: idle level of sck.
- CPHA, default 1: 0 means sample on the leading edge; 1 means sample on the trailing edge.
- LSB_FIRST, default 0: 0 shifts MSB first; 1 shifts LSB first.
- SYNC_STAGES, default 2: synchroniser depth for sck, csn and mosi, legal range 2..4.

REQ-002 The block SHALL have these ports (clock and reset first):
- clk  input  1  system clock; the block has one clock.
- rstn  input  1  reset, synchronous, active-low.
- csn  input  1  chip select, active low, asynchronous to clk.
- sck  input  1  SPI clock, asynchronous to clk.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  miso drive enable; high while the select is synchronised active.
- tx_data  input  WIDTH  next word to transmit.
- tx_valid  input  1  tx_data offered.
- tx_ready  output  1  transmit holding buffer empty.
- rx_data  output  WIDTH  last complete received word.
- rx_valid  output  1  one-clk pulse: rx_data updated.
- tx_underrun  output  1  one-clk pulse: a word load found the holding buffer empty.
- busy  output  1  FSM in ACTIVE.

Function
REQ-003 sck, csn and mosi SHALL each pass through a SYNC_STAGES flop synchroniser before use; sck and csn edges SHALL be detected from the last two synchronised samples.
REQ-004 The leading edge SHALL be the sck transition away from CPOL; the trailing edge SHALL be the return to CPOL.
REQ-005 The sample edge SHALL be the leading edge when CPHA=0 and the trailing edge when CPHA=1; the shift edge SHALL be the other edge.
REQ-006 The FSM SHALL have two states, IDLE and ACTIVE:
- IDLE to ACTIVE on a synchronised csn falling edge.
- ACTIVE to IDLE on a synchronised csn rising edge.
- sck edges SHALL be ignored in IDLE.
REQ-007 The bit counter SHALL run from 0 to WIDTH-1:
- It SHALL increment on each sample edge in ACTIVE and wrap to 0 after WIDTH-1.
- It SHALL clear on entry to IDLE.
REQ-008 On the sample edge of bit WIDTH-1, the assembled word SHALL be written to rx_data, and rx_valid SHALL pulse high for exactly 1 clk, 1 clk after the synchronised edge is detected.
REQ-009 Words SHALL be assembled MSB first when LSB_FIRST=0 and LSB first otherwise; the same order SHALL apply to miso.
REQ-010 A csn deassertion mid-word SHALL discard the partial word: no rx_valid, rx_data unchanged.
REQ-011 The transmit holding buffer SHALL hold 1 word:
- tx_ready SHALL be high whenever the buffer is empty.
- The buffer SHALL accept a word on any clk where tx_valid and tx_ready are both high.
- tx_ready SHALL go low the next clk.
REQ-012 A word load into the output shift register SHALL occur at these points:
- CPHA=0: on IDLE to ACTIVE, and on the shift edge following bit WIDTH-1.
- CPHA=1: on the first shift edge of each word (bit counter 0).
REQ-013 At a load, if the buffer is full its word SHALL move to the shift register and the buffer SHALL become empty; if the buffer is empty, all-zeros SHALL be loaded and tx_underrun SHALL pulse 1 clk.
REQ-014 A load and a tx_valid&&tx_ready acceptance in the same clk SHALL both take effect, with the new word remaining in the buffer.
REQ-015 On shift edges that are not load points, the shift register SHALL advance by 1 bit.
REQ-016 miso SHALL always present the current output bit of the shift register.
REQ-017 miso_oe SHALL be low in IDLE and high in ACTIVE.

Reset
REQ-018 While rstn is low at a clk rising edge, the block SHALL reset as follows:
- FSM to IDLE.
- Bit counter, shift register, holding buffer and rx_data to 0.
- tx_ready=1; rx_valid=0; tx_underrun=0; busy=0; miso_oe=0; miso=0.
REQ-019 The sck synchroniser SHALL reset to CPOL and the csn synchroniser SHALL reset to 1, so that releasing reset never creates a spurious edge.
REQ-020 A reset asserted mid-word SHALL abort the transfer; after release, the block SHALL wait for a fresh csn falling edge.

Structure
REQ-021 Package spi_pkg SHALL hold the SPI mode constants (MODE0..MODE3 as {CPOL,CPHA}) and the FSM state encoding.
REQ-022 Sub-module spi_edge_sync (synchroniser plus rise/fall detect, parametrised by depth and reset level) SHALL be instantiated once each for sck and csn; mosi SHALL use a plain synchroniser.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Mode 3, WIDTH=8: master sends 0xA5 while tx_data=0x3C is preloaded -> rx_data=0xA5 with a single rx_valid pulse; master receives 0x3C.
- Mode 0, WIDTH=16, LSB_FIRST=1: master sends 0x1234 then 0xBEEF in one csn frame, with 0xCAFE and 0x0F0F fed back-to-back -> 2 rx_valid pulses (0x1234, 0xBEEF); master receives 0xCAFE, then 0x0F0F.
- Holding buffer never written, mode 1: 8-bit transfer -> tx_underrun pulses once at the first load, master receives 0x00, rx still correct.
- csn released after 5 of 8 bits, then a full 0x81 transfer -> no rx_valid for the partial word, then rx_data=0x81.
- rstn pulsed low after 3 bits, then a full 0x7E transfer -> all outputs at reset values during reset, no rx_valid for the aborted word, then rx_data=0x7E.
- sck toggling with csn high -> no rx_valid, miso_oe=0, bit counter stays 0.
